bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter_pkg.sv | 30 +++
 rtl/bus_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for bus_arbiter.
// Holds the bus field widths, the arbiter state encoding and the master
// selection function used in the IDLE state.
// The optional macro BUS_ARBITER_ROUND_ROBIN_EN is consumed by bus_arbiter,
// which passes the appropriate conflict winner into select_master.
package bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } arbiter_state_t;

  // Returns the master to route: the sole requester, or prio on a conflict.
  // With no requester the last-served master is kept so the muxes stay quiet.
  function automatic logic select_master(input logic valid0, input logic valid1,
                                         input logic last, input logic prio);
    logic sel;
    if (valid0 && valid1) sel = prio;
    else if (valid0)      sel = 1'b0;
    else if (valid1)      sel = 1'b1;
    else                  sel = last;
    return sel;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master to one-slave bus arbiter placed in front of the single-port RAM.
// m0 is instruction fetch, m1 is load/store. A granted transaction sees zero
// added latency; the grant is locked from first valid until the slave's ready
// so a multi-cycle read is never split between masters.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   m0_* / m1_*                master side: address, valid, wstrobe, wdata in;
//                              ready, rdata out
//   s_*                        slave side: address, valid, wstrobe, wdata out;
//                              ready, rdata in
//
// Parameter FIRST_PRIORITY: conflict winner in fixed-priority mode, and the
// first conflict winner after reset in round-robin mode.
// Macro BUS_ARBITER_ROUND_ROBIN_EN: when defined, conflicts alternate based on
// the last master served; otherwise FIRST_PRIORITY always wins.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned FIRST_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_valid,
  input  logic [STRB_W-1:0] m0_wstrobe,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_valid,
  input  logic [STRB_W-1:0] m1_wstrobe,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_valid,
  output logic [STRB_W-1:0] s_wstrobe,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata
);

  localparam logic FIRST_PRIO = 1'(FIRST_PRIORITY);

  arbiter_state_t state_q, state_d;
  logic           rr_last_q, rr_last_d;
  logic           owner;
  logic           idle_sel;
  logic           conflict_prio;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  assign conflict_prio = ~rr_last_q;
`else
  assign conflict_prio = FIRST_PRIO;
`endif

  assign idle_sel = select_master(m0_valid, m1_valid, rr_last_q, conflict_prio);

  // State and last-served registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= ~FIRST_PRIO;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Next state and current owner; the grant is frozen while in OWN_x.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner     = 1'b0;
    unique case (state_q)
      IDLE: begin
        owner = idle_sel;
        if (m0_valid || m1_valid) begin
          if (s_ready) rr_last_d = idle_sel;
          else         state_d   = idle_sel ? OWN_M1 : OWN_M0;
        end
      end
      OWN_M0: begin
        owner = 1'b0;
        if (!m0_valid) begin
          state_d = IDLE;
        end else if (s_ready) begin
          state_d   = IDLE;
          rr_last_d = 1'b0;
        end
      end
      OWN_M1: begin
        owner = 1'b1;
        if (!m1_valid) begin
          state_d = IDLE;
        end else if (s_ready) begin
          state_d   = IDLE;
          rr_last_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Routing: owner's request to the slave, slave ready to the owner only.
  // Reset gates the request so nothing reaches the RAM mid-reset.
  always_comb begin
    s_address = owner ? m1_address : m0_address;
    s_wdata   = owner ? m1_wdata   : m0_wdata;
    s_valid   = (owner ? m1_valid : m0_valid) && !reset;
    s_wstrobe = s_valid ? (owner ? m1_wstrobe : m0_wstrobe) : '0;
    m0_ready  = s_valid && !owner && s_ready;
    m1_ready  = s_valid &&  owner && s_ready;
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a small behavioural RAM on the slave
// side (writes complete in the first cycle of valid, reads on the second).
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] m0_address, m1_address, s_address;
  logic        m0_valid, m1_valid, s_valid;
  logic [3:0]  m0_wstrobe, m1_wstrobe, s_wstrobe;
  logic [31:0] m0_wdata, m1_wdata, s_wdata;
  logic        m0_ready, m1_ready, s_ready;
  logic [31:0] m0_rdata, m1_rdata, s_rdata;

  logic [31:0] mem [16];
  logic        pend;

  int checks   = 0;
  int failures = 0;
  int cnt0, cnt1;

  always #5 clk = ~clk;

  bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .m0_address (m0_address),
    .m0_valid   (m0_valid),
    .m0_wstrobe (m0_wstrobe),
    .m0_wdata   (m0_wdata),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_address (m1_address),
    .m1_valid   (m1_valid),
    .m1_wstrobe (m1_wstrobe),
    .m1_wdata   (m1_wdata),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_address  (s_address),
    .s_valid    (s_valid),
    .s_wstrobe  (s_wstrobe),
    .s_wdata    (s_wdata),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata)
  );

  // RAM model: ready on the second cycle of a read, same cycle for a write.
  assign s_ready = s_valid && ((s_wstrobe != 4'd0) || pend);
  assign s_rdata = mem[s_address[5:2]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 | 32'(i);
    end else begin
      pend <= s_valid && (s_wstrobe == 4'd0) && !pend;
      if (s_valid && s_ready)
        for (int b = 0; b < 4; b++)
          if (s_wstrobe[b]) mem[s_address[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_address = 32'h0; m0_valid = 1'b1; m0_wstrobe = 4'hF; m0_wdata = 32'h0;
    m1_address = 32'h0; m1_valid = 1'b1; m1_wstrobe = 4'hF; m1_wdata = 32'h0;

    // Outputs held quiet during reset even with both masters requesting.
    @(negedge clk);
    check("rst_s_valid",   32'(s_valid),   32'd0);
    check("rst_s_wstrobe", 32'(s_wstrobe), 32'd0);
    check("rst_m0_ready",  32'(m0_ready),  32'd0);
    check("rst_m1_ready",  32'(m1_ready),  32'd0);
    m0_valid = 1'b0; m1_valid = 1'b0; m0_wstrobe = 4'h0; m1_wstrobe = 4'h0;
    tick();
    reset = 1'b0;

    // Single m0 read of 0x10.
    tick();
    m0_valid = 1'b1; m0_address = 32'h10;
    @(negedge clk);
    check("rd1_c1_s_valid", 32'(s_valid),  32'd1);
    check("rd1_c1_s_addr",  s_address,     32'h10);
    check("rd1_c1_m0_rdy",  32'(m0_ready), 32'd0);
    tick(); @(negedge clk);
    check("rd1_c2_s_valid", 32'(s_valid),  32'd1);
    check("rd1_c2_m0_rdy",  32'(m0_ready), 32'd1);
    check("rd1_c2_rdata",   m0_rdata,      32'h1000_0004);
    check("rd1_c2_m1_rdy",  32'(m1_ready), 32'd0);

    // Conflict: m0 read 0x0 against m1 write 0x8; m0 has fixed priority.
    tick();
    m0_valid = 1'b1; m0_address = 32'h0;
    m1_valid = 1'b1; m1_address = 32'h8; m1_wstrobe = 4'hF; m1_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("cf_c1_s_addr", s_address,     32'h0);
    check("cf_c1_m0_rdy", 32'(m0_ready), 32'd0);
    check("cf_c1_m1_rdy", 32'(m1_ready), 32'd0);
    tick(); @(negedge clk);
    check("cf_c2_m0_rdy", 32'(m0_ready), 32'd1);
    check("cf_c2_rdata",  m0_rdata,      32'h1000_0000);
    check("cf_c2_m1_rdy", 32'(m1_ready), 32'd0);
    tick();
    m0_valid = 1'b0;
    @(negedge clk);
    check("cf_c3_m1_rdy",  32'(m1_ready),  32'd1);
    check("cf_c3_s_addr",  s_address,      32'h8);
    check("cf_c3_s_strb",  32'(s_wstrobe), 32'hF);
    check("cf_c3_m0_rdy",  32'(m0_ready),  32'd0);
    tick();
    m1_valid = 1'b0; m1_wstrobe = 4'h0;
    m0_valid = 1'b1; m0_address = 32'h8;
    @(negedge clk);
    check("rb8_c1_m0_rdy", 32'(m0_ready), 32'd0);
    tick(); @(negedge clk);
    check("rb8_c2_m0_rdy", 32'(m0_ready), 32'd1);
    check("rb8_c2_rdata",  m0_rdata,      32'hDEAD_BEEF);

    // m1 requests during the first cycle of an m0 read; grant stays with m0.
    tick();
    m0_address = 32'h14;
    @(negedge clk);
    check("lk_c1_s_addr", s_address, 32'h14);
    #1;
    m1_valid = 1'b1; m1_address = 32'h18; m1_wstrobe = 4'h0;
    tick(); @(negedge clk);
    check("lk_c2_s_addr", s_address,     32'h14);
    check("lk_c2_m1_rdy", 32'(m1_ready), 32'd0);
    check("lk_c2_m0_rdy", 32'(m0_ready), 32'd1);
    check("lk_c2_rdata",  m0_rdata,      32'h1000_0005);
    tick();
    m0_valid = 1'b0;
    @(negedge clk);
    check("lk_c3_s_addr", s_address,     32'h18);
    check("lk_c3_m1_rdy", 32'(m1_ready), 32'd0);
    tick(); @(negedge clk);
    check("lk_c4_m1_rdy", 32'(m1_ready), 32'd1);
    check("lk_c4_rdata",  m1_rdata,      32'h1000_0006);

    // Owner drops valid mid-read: request vanishes, then m1 byte write.
    tick();
    m1_valid = 1'b0;
    m0_valid = 1'b1; m0_address = 32'h0;
    @(negedge clk);
    check("ab_c1_m0_rdy", 32'(m0_ready), 32'd0);
    tick();
    m0_valid = 1'b0;
    m1_valid = 1'b1; m1_address = 32'h4; m1_wstrobe = 4'b0010; m1_wdata = 32'h0000_AB00;
    @(negedge clk);
    check("ab_c2_s_valid", 32'(s_valid),  32'd0);
    check("ab_c2_m1_rdy",  32'(m1_ready), 32'd0);
    tick(); @(negedge clk);
    check("bw_m1_rdy",  32'(m1_ready), 32'd1);
    check("bw_s_addr",  s_address,     32'h4);
    check("bw_s_strb",  32'(s_wstrobe), 32'h2);

    // Immediate m0 read of the byte-written word with no dead cycle.
    tick();
    m1_valid = 1'b0; m1_wstrobe = 4'h0;
    m0_valid = 1'b1; m0_address = 32'h4;
    @(negedge clk);
    check("bwr_c1_s_valid", 32'(s_valid),  32'd1);
    check("bwr_c1_s_addr",  s_address,     32'h4);
    check("bwr_c1_m0_rdy",  32'(m0_ready), 32'd0);
    tick(); @(negedge clk);
    check("bwr_c2_m0_rdy", 32'(m0_ready), 32'd1);
    check("bwr_c2_rdata",  m0_rdata,      32'h1000_AB01);

    // Both masters reading continuously for 20 cycles.
    tick();
    m0_valid = 1'b1; m0_address = 32'h0;
    m1_valid = 1'b1; m1_address = 32'h8;
    cnt0 = 0; cnt1 = 0;
    repeat (20) begin
      @(negedge clk);
      cnt0 += int'(m0_ready);
      cnt1 += int'(m1_ready);
    end
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    check("cont_m0_cnt", 32'(cnt0), 32'd5);
    check("cont_m1_cnt", 32'(cnt1), 32'd5);
`else
    check("cont_m0_cnt", 32'(cnt0), 32'd10);
    check("cont_m1_cnt", 32'(cnt1), 32'd0);
`endif
    tick();
    m1_valid = 1'b0;

    // Reset while m0 owns the bus, then the held read restarts cleanly.
    m0_address = 32'h10;
    @(negedge clk);
    check("rs_c1_m0_rdy", 32'(m0_ready), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rs_async_m0_rdy",  32'(m0_ready), 32'd0);
    check("rs_async_s_valid", 32'(s_valid),  32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rs_r1_s_valid", 32'(s_valid),  32'd1);
    check("rs_r1_m0_rdy",  32'(m0_ready), 32'd0);
    tick(); @(negedge clk);
    check("rs_r2_m0_rdy", 32'(m0_ready), 32'd1);
    check("rs_r2_rdata",  m0_rdata,      32'h1000_0004);
    tick();
    m0_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
